// File: rtl/kuznechik_apb_master.sv
// APB initiator for the memory-mapped Kuznechik peripheral: turns each plaintext
// block from the input stream into a full write/request/poll/read/ack sequence.
module kuznechik_apb_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned POLL_LIMIT     = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      blk_valid_i,
  output logic                      blk_ready_o,
  input  logic [127:0]              blk_data_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [127:0]              res_data_o,
  output logic                      res_err_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_WR_DIN  = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_POLL    = 3'd4;
  localparam logic [2:0] S_RD_DOUT = 3'd5;
  localparam logic [2:0] S_WR_ACK  = 3'd6;
  localparam logic [2:0] S_RESP    = 3'd7;

  localparam logic [1:0] PH_GAP    = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_ACCESS = 2'd2;

  localparam logic [7:0] A_RST   = 8'h00;
  localparam logic [7:0] A_REQ   = 8'h04;
  localparam logic [7:0] A_ACK   = 8'h08;
  localparam logic [7:0] A_VALID = 8'h0C;
  localparam logic [7:0] A_DIN0  = 8'h14;
  localparam logic [7:0] A_DOUT0 = 8'h24;

  logic [2:0]                state_q, state_d;
  logic [1:0]                ph_q, ph_d;
  logic [1:0]                idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                      err_q, err_d;
  logic [BLK_W-1:0]          blk_q, blk_d, res_q, res_d;
  logic                      blk_ready_d, res_valid_d, res_err_d;
  logic [BLK_W-1:0]          res_data_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_d;
  logic                      pwrite_d, psel_d, penable_d;

  logic                      xfer_en, xfer_wr, xfer_done, ack_err;
  logic [7:0]                xfer_addr, word_off;
  logic [31:0]               xfer_wdata;

  assign xfer_done = (ph_q == PH_ACCESS) && apb_pready_i;
  assign word_off  = {4'd0, idx_q, 2'b00};
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign ack_err   = err_q | apb_pslverr_i;

  // Sequencer plus the SETUP/ACCESS/gap engine shared by every transfer step
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    blk_d       = blk_q;
    res_d       = res_q;
    blk_ready_d = blk_ready_o;
    res_valid_d = res_valid_o;
    res_data_d  = res_data_o;
    res_err_d   = res_err_o;
    paddr_d     = apb_paddr_o;
    pwdata_d    = apb_pwdata_o;
    pwrite_d    = apb_pwrite_o;
    psel_d      = apb_psel_o;
    penable_d   = apb_penable_o;
    xfer_en     = 1'b0;
    xfer_wr     = 1'b1;
    xfer_addr   = A_RST;
    xfer_wdata  = 32'd1;

    case (state_q)
      S_INIT: begin
        xfer_en = 1'b1;
        // slave error on the reset write is deliberately ignored
        if (xfer_done) begin
          state_d     = S_IDLE;
          blk_ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (blk_valid_i && blk_ready_o) begin
          blk_d       = blk_data_i;
          res_d       = '0;
          err_d       = 1'b0;
          idx_d       = 2'd0;
          blk_ready_d = 1'b0;
          state_d     = S_WR_DIN;
        end
      end
      S_WR_DIN: begin
        xfer_en    = 1'b1;
        xfer_addr  = A_DIN0 + word_off;
        xfer_wdata = blk_q[{idx_q, 5'b0} +: 32];
        if (xfer_done) begin
          if (apb_pslverr_i) begin
            err_d   = 1'b1;
            state_d = S_WR_ACK;
          end else if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = S_WR_REQ;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WR_REQ: begin
        xfer_en   = 1'b1;
        xfer_addr = A_REQ;
        if (xfer_done) begin
          err_d   = apb_pslverr_i;
          cnt_d   = '0;
          state_d = apb_pslverr_i ? S_WR_ACK : S_POLL;
        end
      end
      S_POLL: begin
        xfer_en   = 1'b1;
        xfer_wr   = 1'b0;
        xfer_addr = A_VALID;
        if (xfer_done) begin
          if (apb_pslverr_i) begin
            err_d   = 1'b1;
            state_d = S_WR_ACK;
          end else if (apb_prdata_i[0]) begin
            idx_d   = 2'd0;
            state_d = S_RD_DOUT;
          end else if (cnt_inc == CNT_W'(POLL_LIMIT)) begin
            err_d   = 1'b1;
            state_d = S_WR_ACK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_RD_DOUT: begin
        xfer_en   = 1'b1;
        xfer_wr   = 1'b0;
        xfer_addr = A_DOUT0 + word_off;
        if (xfer_done) begin
          res_d[{idx_q, 5'b0} +: 32] = 32'(apb_prdata_i);
          if (apb_pslverr_i) begin
            err_d   = 1'b1;
            state_d = S_WR_ACK;
          end else if (idx_q == 2'd3) begin
            state_d = S_WR_ACK;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WR_ACK: begin
        xfer_en   = 1'b1;
        xfer_addr = A_ACK;
        if (xfer_done) begin
          err_d       = ack_err;
          res_err_d   = ack_err;
          res_data_d  = ack_err ? '0 : res_q;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          blk_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    // gap cycle (psel low) before every SETUP keeps transfers from running back-to-back
    if (xfer_en) begin
      case (ph_q)
        PH_GAP: begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = APB_ADDR_WIDTH'(xfer_addr);
          pwrite_d  = xfer_wr;
          pwdata_d  = xfer_wr ? APB_DATA_WIDTH'(xfer_wdata) : '0;
          ph_d      = PH_SETUP;
        end
        PH_SETUP: begin
          penable_d = 1'b1;
          ph_d      = PH_ACCESS;
        end
        PH_ACCESS: begin
          if (apb_pready_i) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            ph_d      = PH_GAP;
          end
        end
        default: ph_d = PH_GAP;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_INIT;
      ph_q          <= PH_GAP;
      idx_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      blk_q         <= '0;
      res_q         <= '0;
      blk_ready_o   <= 1'b0;
      res_valid_o   <= 1'b0;
      res_data_o    <= '0;
      res_err_o     <= 1'b0;
      apb_paddr_o   <= '0;
      apb_pwdata_o  <= '0;
      apb_pwrite_o  <= 1'b0;
      apb_psel_o    <= 1'b0;
      apb_penable_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      blk_q         <= blk_d;
      res_q         <= res_d;
      blk_ready_o   <= blk_ready_d;
      res_valid_o   <= res_valid_d;
      res_data_o    <= res_data_d;
      res_err_o     <= res_err_d;
      apb_paddr_o   <= paddr_d;
      apb_pwdata_o  <= pwdata_d;
      apb_pwrite_o  <= pwrite_d;
      apb_psel_o    <= psel_d;
      apb_penable_o <= penable_d;
    end
  end

endmodule

// File: doc/kuznechik_apb_master.md
Name: kuznechik_apb_master

Overview:
- APB initiator that runs complete encryptions on the memory-mapped Kuznechik cipher peripheral.
- Accepts a 128-bit plaintext block on a valid/ready stream.
- Sequences the APB transfers: write data, request, poll VALID, read result, acknowledge.
- Returns the 128-bit ciphertext on an output valid/ready stream.
- Sits between an on-chip DMA/stream source and the APB bus, so the CPU is not needed per block.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width.
- APB_DATA_WIDTH, 32, APB data width; fixed at 32 for the 4-word block split.
- POLL_LIMIT, 1024, maximum VALID-register reads per block before timeout.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- blk_valid_i  in  1  plaintext block offered.
- blk_ready_o  out  1  block accepted when high with blk_valid_i.
- blk_data_i  in  128  plaintext block.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  consumer takes result.
- res_data_o  out  128  ciphertext.
- res_err_o  out  1  result invalid: slave error or poll timeout; qualified by res_valid_o.
- apb_paddr_o  out  APB_ADDR_WIDTH  APB address.
- apb_pwdata_o  out  32  APB write data.
- apb_pwrite_o  out  1  APB direction.
- apb_psel_o  out  1  APB select.
- apb_penable_o  out  1  APB enable.
- apb_prdata_i  in  32  APB read data.
- apb_pready_i  in  1  APB ready.
- apb_pslverr_i  in  1  APB slave error.

Behaviour:
- Reset values: all outputs 0; internal result and error registers 0.
- Slave register map (byte addresses):
  - RST 0x00, REQ 0x04, ACK 0x08, VALID 0x0C, BUSY 0x10.
  - DATA_IN_0..3 at 0x14/0x18/0x1C/0x20.
  - DATA_OUT_0..3 at 0x24/0x28/0x2C/0x30.
  - Word n maps to bits [32n+31:32n].
- APB transfer engine:
  - SETUP cycle: psel=1, penable=0, paddr/pwrite/pwdata valid.
  - ACCESS: psel=1, penable=1, held until pready=1.
  - Next cycle: psel=0 for at least one cycle (no back-to-back transfers).
  - prdata and pslverr are sampled only in the ACCESS cycle where pready=1.
  - Address, write and wdata are stable from SETUP through the completing ACCESS.
- Sequencer states:
  - INIT: after reset, write RST=1 once, then go to IDLE.
  - IDLE: blk_ready_o=1. On blk_valid_i&blk_ready_o, capture blk_data_i and go to WR_DIN.
  - WR_DIN: write DATA_IN_0..3 in order 0,1,2,3.
  - WR_REQ: write REQ=1 (the slave self-clears it).
  - POLL: read VALID.
    - bit0=1: go to RD_DOUT.
    - bit0=0: issue another read, incrementing the poll counter.
    - Counter reaches POLL_LIMIT: set err and go to WR_ACK.
  - RD_DOUT: read DATA_OUT_0..3 into the result register.
  - WR_ACK: write ACK=1 (the slave self-clears it).
  - RESP: res_valid_o=1; res_data_o/res_err_o held stable until res_ready_i, then go to IDLE.
- blk_ready_o is high only in IDLE, so at most one block is in flight.
- Error handling:
  - A pslverr on any transfer sets err.
  - After a pslverr, the remaining DATA_IN/REQ/POLL/RD steps are skipped; the ACK write is still issued, then RESP.
  - res_data_o is 0 when res_err_o=1.
  - The error register clears on the next block accept.
  - A pslverr during INIT is ignored; the block still proceeds to IDLE.
- Poll counter: clog2(POLL_LIMIT+1) bits, cleared on entry to POLL. Timeout fires exactly after POLL_LIMIT VALID reads that all returned 0.
- res_ready_i held high entering RESP: result accepted in the first RESP cycle, IDLE on the next cycle.
- rstn_i asserted mid-transfer: psel/penable drop immediately (async), state returns to INIT, captured data is discarded.
- Minimum latency with zero-wait slave and VALID=1 on first poll: 11 transfers × 3 cycles.

Test Plan:
- Zero-wait slave model:
  - After reset, exactly one write of 0x1 to 0x00 precedes IDLE.
  - Block 0x1122334455667700ffeeddccbbaa9988 gives writes 0xbbaa9988 @0x14, 0xffeeddcc @0x18, 0x55667700 @0x1C, 0x11223344 @0x20, then 0x1 @0x04.
- Real cipher as slave: plaintext 1122334455667700ffeeddccbbaa9988 -> res_data_o=7f679d90bebc24305a468d42b9d4edcd, res_err_o=0.
- Slave inserts 3 wait states per transfer and VALID=0 for 5 polls:
  - Exactly 6 reads of 0x0C.
  - paddr/pwdata stable through the wait states.
  - Correct result.
- POLL_LIMIT=4 with VALID never set:
  - 4 reads of 0x0C, then write 0x1 @0x08.
  - res_valid_o=1, res_err_o=1, res_data_o=0.
- pslverr on the DATA_IN_2 write:
  - No DATA_IN_3 or REQ write; ACK write still issued.
  - res_err_o=1.
  - Next block clears err and completes normally.
- res_ready_i low for 10 cycles: res_valid_o and res_data_o stable, blk_ready_o=0, no APB activity.
- rstn_i pulsed during POLL: psel=0 the same cycle, then the RST write is reissued.
